// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the clock-enable divider controller.
package clk_div_pkg;

    // Controller states: IDLE holds the output low, RUN produces periods.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest ratio that still yields both a high and a low phase.
    localparam int MIN_DIV = 2;

    // Length of the high phase for a period of n cycles (odd n gets the extra low cycle).
    function automatic logic [31:0] half_of(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and registered waveform generator. The controller above
// decides when periods start and stop and which ratio the next cycle uses;
// this block only counts and shapes clk_out / tick.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,        // controller currently in RUN
    input  logic             start,      // IDLE -> RUN transition this cycle
    input  logic             halt_req,   // stop if this cycle ends a period
    input  logic [DIV_W-1:0] active,     // ratio of the period in progress
    input  logic [DIV_W-1:0] next_div,   // ratio in force next cycle
    output logic [DIV_W-1:0] cnt,
    output logic             clk_out,
    output logic             tick,
    output logic             period_end
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_next;
    logic             going;
    logic [31:0]      high_len;

    // Next counter value and whether a period is running next cycle.
    always_comb begin
        period_end = run && (cnt == active - ONE);
        going      = start || (run && !(period_end && halt_req));
        cnt_next   = '0;
        if (run && !period_end) begin
            cnt_next = cnt + ONE;
        end
        // The high length follows the ratio of the period being entered,
        // so a ratio swapped in at a boundary shapes its first cycle too.
        high_len   = half_of(32'(next_div));
    end

    // Counter and waveform registers move together so clk_out never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= going ? cnt_next : '0;
            clk_out <= going && (32'(cnt_next) < high_len);
            tick    <= going && (cnt_next == '0);
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Runtime-programmable divider controller: run/stop FSM, ratio handshake,
// single pending-ratio slot and the bad-ratio error pulse. Ratio and
// run/stop changes only take effect at period boundaries.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             pend,
    output logic [DIV_W-1:0] cur_div
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    state_t           state;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] pending;
    logic [DIV_W-1:0] active_next;
    logic [DIV_W-1:0] cnt;
    logic             xfer;
    logic             cfg_ok;
    logic             cfg_load;
    logic             period_end;
    logic             start;

    assign cfg_ready = !pend;
    assign busy      = (state == RUN);
    assign cur_div   = active;

    // Handshake decode and the ratio that will be active next cycle.
    always_comb begin
        xfer        = cfg_valid && cfg_ready;
        cfg_ok      = (32'(cfg_div) >= MIN_DIV);
        cfg_load    = xfer && cfg_ok;
        start       = (state == IDLE) && en;
        active_next = active;
        if (state == IDLE) begin
            if (cfg_load) begin
                active_next = cfg_div;
            end
        end else if (period_end) begin
            // A ratio arriving exactly at the boundary skips the slot; the
            // slot is necessarily empty then because cfg_ready was high.
            if (cfg_load) begin
                active_next = cfg_div;
            end else if (pend) begin
                active_next = pending;
            end
        end
    end

    // Control FSM with the pending slot and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            active  <= RESET_DIV;
            pending <= RESET_DIV;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= xfer && !cfg_ok;
            active  <= active_next;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (period_end) begin
                        // The slot is drained at every boundary, stop included.
                        pend <= 1'b0;
                        if (!en) begin
                            state <= IDLE;
                        end
                    end else if (cfg_load) begin
                        pending <= cfg_div;
                        pend    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .run        (state == RUN),
        .start      (start),
        .halt_req   (!en),
        .active     (active),
        .next_div   (active_next),
        .cnt        (cnt),
        .clk_out    (clk_out),
        .tick       (tick),
        .period_end (period_end)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed self-checking bench for clk_div_sched.
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       pend;
    logic [7:0] cur_div;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clk_div_sched #(
        .DIV_W       (8),
        .DEFAULT_DIV (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .pend      (pend),
        .cur_div   (cur_div)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check n consecutive cycles of clk_out/tick against MSB-first patterns.
    task automatic run_check(input string tag, input int n,
                             input logic [63:0] cpat, input logic [63:0] tpat);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s clk_out[%0d]", tag, i), 32'(clk_out), 32'(cpat[n-1-i]));
            chk($sformatf("%s tick[%0d]", tag, i), 32'(tick), 32'(tpat[n-1-i]));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " clk_out"}, 32'(clk_out), 32'd0);
        chk({tag, " tick"}, 32'(tick), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " pend"}, 32'(pend), 32'd0);
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'd1);
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
        chk({tag, " cur_div"}, 32'(cur_div), 32'd6);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;

        // Free run at default N=6: 111000, first tick one cycle after en.
        en = 1'b1;
        run_check("n6", 12, 64'b111000111000, 64'b100000100000);
        chk("n6 cur_div", 32'(cur_div), 32'd6);
        chk("n6 busy", 32'(busy), 32'd1);

        // Offer N=4 at cnt=1: held pending until the boundary.
        step();                                      // cnt0
        chk("p4 c0 tick", 32'(tick), 32'd1);
        step();                                      // cnt1
        cfg_valid = 1'b1; cfg_div = 8'd4;
        step();                                      // cnt2
        cfg_valid = 1'b0;
        chk("p4 pend", 32'(pend), 32'd1);
        chk("p4 cfg_ready", 32'(cfg_ready), 32'd0);
        chk("p4 clk c2", 32'(clk_out), 32'd1);
        chk("p4 cur_div mid", 32'(cur_div), 32'd6);
        run_check("p4 tail", 3, 64'b000, 64'b000);   // cnt3..5
        chk("p4 pend tail", 32'(pend), 32'd1);
        chk("p4 cur_div tail", 32'(cur_div), 32'd6);
        step();                                      // new period cnt0
        chk("p4 b clk", 32'(clk_out), 32'd1);
        chk("p4 b tick", 32'(tick), 32'd1);
        chk("p4 b pend", 32'(pend), 32'd0);
        chk("p4 b cfg_ready", 32'(cfg_ready), 32'd1);
        chk("p4 b cur_div", 32'(cur_div), 32'd4);
        run_check("n4", 7, 64'b1001100, 64'b0001000); // ends at cnt3

        // Bad ratios in RUN: error pulse only.
        cfg_valid = 1'b1; cfg_div = 8'd1;
        step();                                      // cnt0
        chk("err1 cfg_err", 32'(cfg_err), 32'd1);
        chk("err1 tick", 32'(tick), 32'd1);
        chk("err1 cur_div", 32'(cur_div), 32'd4);
        chk("err1 pend", 32'(pend), 32'd0);
        cfg_div = 8'd0;
        step();                                      // cnt1
        cfg_valid = 1'b0;
        chk("err0 cfg_err", 32'(cfg_err), 32'd1);
        chk("err0 clk", 32'(clk_out), 32'd1);
        chk("err0 pend", 32'(pend), 32'd0);
        step();                                      // cnt2
        chk("err clr", 32'(cfg_err), 32'd0);
        chk("err c2 clk", 32'(clk_out), 32'd0);
        chk("err cur_div", 32'(cur_div), 32'd4);

        // Queue N=5, then drop en at cnt=2: period completes, then IDLE.
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();                                      // cnt3
        cfg_valid = 1'b0;
        chk("p5 pend", 32'(pend), 32'd1);
        step();                                      // N5 cnt0
        chk("p5 cur_div", 32'(cur_div), 32'd5);
        chk("p5 tick", 32'(tick), 32'd1);
        step();                                      // cnt1
        chk("p5 c1 clk", 32'(clk_out), 32'd1);
        step();                                      // cnt2
        chk("p5 c2 clk", 32'(clk_out), 32'd0);
        en = 1'b0;
        step();                                      // cnt3
        chk("stop c3 busy", 32'(busy), 32'd1);
        step();                                      // cnt4
        chk("stop c4 busy", 32'(busy), 32'd1);
        chk("stop c4 clk", 32'(clk_out), 32'd0);
        step();                                      // IDLE
        chk("stop busy", 32'(busy), 32'd0);
        chk("stop clk", 32'(clk_out), 32'd0);
        chk("stop tick", 32'(tick), 32'd0);
        step();
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle cur_div", 32'(cur_div), 32'd5);

        // Short en drop re-raised before period end: no stop.
        en = 1'b1;
        step();                                      // cnt0
        chk("glitch start tick", 32'(tick), 32'd1);
        chk("glitch start clk", 32'(clk_out), 32'd1);
        step();                                      // cnt1
        step();                                      // cnt2
        en = 1'b0;
        step();                                      // cnt3
        en = 1'b1;
        step();                                      // cnt4
        step();                                      // next cnt0
        chk("glitch busy", 32'(busy), 32'd1);
        chk("glitch tick", 32'(tick), 32'd1);
        chk("glitch clk", 32'(clk_out), 32'd1);

        // Stop again, then bad ratio in IDLE.
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();          // cnt1..4, IDLE
        chk("idle2 busy", 32'(busy), 32'd0);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        step();
        chk("idle err", 32'(cfg_err), 32'd1);
        chk("idle err cur_div", 32'(cur_div), 32'd5);
        chk("idle err busy", 32'(busy), 32'd0);
        chk("idle err clk", 32'(clk_out), 32'd0);

        // Start with N=3 transferred in the same cycle as en.
        en = 1'b1; cfg_div = 8'd3;
        step();                                      // cnt0
        cfg_valid = 1'b0;
        chk("n3 cur_div", 32'(cur_div), 32'd3);
        chk("n3 clk", 32'(clk_out), 32'd1);
        chk("n3 tick", 32'(tick), 32'd1);
        chk("n3 err", 32'(cfg_err), 32'd0);
        run_check("n3", 5, 64'b00100, 64'b00100);    // ends at cnt2

        // N=7 offered exactly at period end: applied directly, no pend.
        cfg_valid = 1'b1; cfg_div = 8'd7;
        step();                                      // cnt0
        cfg_valid = 1'b0;
        chk("n7 cur_div", 32'(cur_div), 32'd7);
        chk("n7 pend", 32'(pend), 32'd0);
        chk("n7 clk", 32'(clk_out), 32'd1);
        chk("n7 tick", 32'(tick), 32'd1);
        run_check("n7", 13, 64'b1100001110000, 64'b0000001000000);

        // Reset mid-period with a pending ratio.
        step();                                      // cnt0
        cfg_valid = 1'b1; cfg_div = 8'd4;
        step();                                      // cnt1
        cfg_valid = 1'b0;
        chk("rst pre pend", 32'(pend), 32'd1);
        step();                                      // cnt2
        chk("rst pre clk", 32'(clk_out), 32'd1);
        rst = 1'b1;
        step();
        chk_reset("midrst");
        rst = 1'b0; en = 1'b0;
        step();
        chk("post rst busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Runtime-programmable clock-enable divider controller, the sequencing block for the team's fixed divide-by-N clock generators.
- Produces a divided waveform `clk_out` plus a one-cycle `tick` at each period start.
- Accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries, so no period is ever truncated.
- Start/stop via `en` is also honoured only at period boundaries.

Parameters:
- DIV_W, 8, width of the divide-ratio field.
- DEFAULT_DIV, 6, active ratio after reset; must be >= 2 and < 2^DIV_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run request; sampled at period end (RUN) or every cycle (IDLE)
- cfg_valid  in  1  new ratio offered
- cfg_div  in  DIV_W  offered ratio N
- cfg_ready  out  1  controller can accept a ratio this cycle
- cfg_err  out  1  one-cycle pulse: accepted ratio was < 2 and was discarded
- clk_out  out  1  divided waveform, registered
- tick  out  1  one-cycle pulse on each `clk_out` period start
- busy  out  1  state == RUN
- pend  out  1  a validated ratio is waiting for the next boundary
- cur_div  out  DIV_W  active ratio

Behaviour:
- Reset (sync, highest priority, including mid-period):
  - state=IDLE, cnt=0, active=DEFAULT_DIV, pend=0.
  - clk_out=0, tick=0, cfg_err=0, cfg_ready=1.
- Handshake:
  - cfg_ready = !pend, combinational from register.
  - Transfer occurs when cfg_valid & cfg_ready.
  - Ratio < 2: cfg_err=1 the next cycle; nothing is stored.
  - Ratio >= 2 in IDLE: active <= cfg_div next cycle.
  - Ratio >= 2 in RUN and not at period end: pending <= cfg_div, pend <= 1.
  - Ratio >= 2 in RUN at period end (cnt==active-1): applied directly as the new active for the next period; pend stays 0.
- Waveform: HIGH = floor(active/2).
  - clk_out=1 while cnt < HIGH, 0 otherwise, registered with cnt.
  - N=6 gives 3 high / 3 low; N=3 gives 1 high / 2 low; N=2 gives 1/1.
- State IDLE:
  - cnt=0, clk_out=0.
  - If en=1: next cycle state=RUN, cnt=0, clk_out=1, tick=1.
  - Start latency is 1 cycle from en.
  - A config transferred in the same cycle is used for that first period.
- State RUN:
  - cnt increments each cycle; tick=0 except on cycles where cnt==0.
  - At period end (cnt==active-1), in priority order:
    - en=0: next state IDLE, clk_out=0. A pending ratio is still loaded into active and pend clears.
    - else, pend=1: active <= pending, pend <= 0, cnt <= 0, tick=1.
    - else: cnt <= 0, tick=1.
- Boundary rules:
  - en drop mid-period: the current period always completes. A pulse of en shorter than the remaining period is ignored if en is back high at period end.
  - Only one pending slot. cfg_ready stays low until the boundary consumes it, so no overwrite is possible.
  - cur_div changes on the cycle cnt returns to 0 (or the cycle after an IDLE transfer); it never changes mid-period.
  - cnt width is DIV_W; it never reaches active, so there is no wrap beyond active-1.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN}
  - MIN_DIV=2
  - function half_of(N) = N>>1
- Sub-module clk_div_core:
  - Inputs: active ratio, run/start controls.
  - Outputs: cnt, clk_out, tick, period_end.
- clk_div_sched holds the FSM, handshake, pending register and error pulse.

Test Plan:
- Reset then en=1 held, no cfg: clk_out pattern 111000 repeating; tick every 6 cycles, first tick 1 cycle after en; cur_div=6, busy=1.
- Running N=6, cfg_div=4 offered at cnt=1: cfg_ready low from the next cycle, pend=1. The current period finishes as 111000, then 1100 repeats; pend=0 and cfg_ready=1 at the boundary.
- cfg_div=1 and cfg_div=0 offered in IDLE and RUN: cfg_err pulses 1 cycle each; cur_div, waveform and pend are unchanged.
- en dropped at cnt=2 of N=5: finishes 11000, then clk_out=0 and busy=0. en re-raised at cnt=3 and held through period end: no stop.
- IDLE with en=1 and cfg_div=3 transferred in the same cycle: the first period is 100 with tick on the first cycle, cur_div=3. Odd N=7 gives 1110000.
- rst asserted mid-period (cnt=2, pend=1): next cycle clk_out=0, busy=0, pend=0, cur_div=6, cfg_ready=1.
